// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the axi_mem_master FSM state type.
package axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        RESP
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_mem_master.sv
// Single-outstanding AXI4 master bridging a simple req/resp memory port to single-beat AXI reads/writes.
// Latency: zero-wait slave gives resp_valid 2 cycles after the AXI address/data handshakes complete.
// Backpressure: req_ready is held low from accept until one cycle after the response handshake; AXI payloads hold while valid.
module axi_mem_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wen,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [2:0]                req_size,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_err,
    output logic [ID_WIDTH-1:0]       awid,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [ID_WIDTH-1:0]       bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [ID_WIDTH-1:0]       arid,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [ID_WIDTH-1:0]       rid,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic                    req_rdy_q, req_rdy_d;
    logic                    aw_vld_q, aw_vld_d;
    logic                    w_vld_q, w_vld_d;
    logic                    b_rdy_q, b_rdy_d;
    logic                    ar_vld_q, ar_vld_d;
    logic                    r_rdy_q, r_rdy_d;
    logic                    resp_vld_q, resp_vld_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              size_q, size_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;

    // Only one transaction is ever in flight, so response IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{bid, rid};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_rdy_q  <= 1'b0;
            aw_vld_q   <= 1'b0;
            w_vld_q    <= 1'b0;
            b_rdy_q    <= 1'b0;
            ar_vld_q   <= 1'b0;
            r_rdy_q    <= 1'b0;
            resp_vld_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_rdy_q  <= req_rdy_d;
            aw_vld_q   <= aw_vld_d;
            w_vld_q    <= w_vld_d;
            b_rdy_q    <= b_rdy_d;
            ar_vld_q   <= ar_vld_d;
            r_rdy_q    <= r_rdy_d;
            resp_vld_q <= resp_vld_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_rdy_d  = req_rdy_q;
        aw_vld_d   = aw_vld_q;
        w_vld_d    = w_vld_q;
        b_rdy_d    = b_rdy_q;
        ar_vld_d   = ar_vld_q;
        r_rdy_d    = r_rdy_q;
        resp_vld_d = resp_vld_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;

        case (state_q)
            IDLE: begin
                req_rdy_d = 1'b1;
                if (req_valid && req_rdy_q) begin
                    req_rdy_d = 1'b0;
                    addr_d    = req_addr;
                    size_d    = req_size;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    if (req_wen) begin
                        aw_vld_d = 1'b1;
                        w_vld_d  = 1'b1;
                        state_d  = WR;
                    end else begin
                        ar_vld_d = 1'b1;
                        state_d  = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    ar_vld_d = 1'b0;
                    r_rdy_d  = 1'b1;
                    state_d  = RD_DATA;
                end
            end
            RD_DATA: begin
                // A beat without rlast is a slave protocol violation; drop it and keep waiting.
                if (rvalid && r_rdy_q && rlast) begin
                    rdata_d    = rdata;
                    err_d      = (rresp != AXI_RESP_OKAY);
                    r_rdy_d    = 1'b0;
                    resp_vld_d = 1'b1;
                    state_d    = RESP;
                end
            end
            WR: begin
                if (aw_vld_q && awready) aw_vld_d = 1'b0;
                if (w_vld_q && wready)   w_vld_d  = 1'b0;
                if (!aw_vld_d && !w_vld_d) begin
                    b_rdy_d = 1'b1;
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid && b_rdy_q) begin
                    err_d      = (bresp != AXI_RESP_OKAY);
                    b_rdy_d    = 1'b0;
                    rdata_d    = '0;
                    resp_vld_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_vld_d = 1'b0;
                    req_rdy_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = req_rdy_q;
    assign resp_valid = resp_vld_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign awid    = ID_WIDTH'(AXI_ID);
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = aw_vld_q;

    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign wlast  = 1'b1;
    assign wvalid = w_vld_q;
    assign bready = b_rdy_q;

    assign arid    = ID_WIDTH'(AXI_ID);
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = size_q;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = ar_vld_q;
    assign rready  = r_rdy_q;

endmodule
